alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 179 +++++++++++++++++
 tb/tb_alu_issue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - single-issue front end for a multi-cycle ALU with flags and timeout
module alu_issue #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  // request stream
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_ins,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  // response stream
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  // flags register
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_o,
  output logic        flag_n,
  // ALU control
  output logic        alu_start,
  output logic        alu_oe,
  output logic        alu_carryin,
  output logic [7:0]  alu_cins,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  // ALU status
  input  logic        alu_done,
  input  logic        alu_carry,
  input  logic        alu_over,
  input  logic        alu_cmp,
  input  logic [15:0] alu_result
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_MODE      = 3'd4
  } state_t;

  localparam logic [7:0] INS_CLR_CMP  = 8'h50;
  localparam logic [7:0] INS_MODE_LO  = 8'h51;
  localparam logic [7:0] INS_MODE_HI  = 8'h54;
  localparam logic [5:0] TIMEOUT_CNT  = 6'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  ins_q;
  logic [15:0] a_q, b_q;
  logic [5:0]  cnt_q;
  logic [5:0]  cnt_inc;
  logic        rsp_valid_q, rsp_err_q;
  logic [15:0] rsp_result_q;
  logic        flag_z_q, flag_c_q, flag_o_q, flag_n_q;
  logic        start_q, oe_q;

  logic        accept;
  logic        req_is_mode;
  logic        in_wait;
  logic        timeout;
  logic        done_hit;
  logic        capture;

  // Handshake and completion decode; the counter value after this cycle's
  // increment is what is compared, so TIMEOUT is the number of wait cycles.
  always_comb begin
    req_is_mode = (req_ins >= INS_MODE_LO) && (req_ins <= INS_MODE_HI);
    accept      = req_valid && (state_q == S_IDLE) && !rsp_valid_q;
    in_wait     = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
    cnt_inc     = cnt_q + 6'd1;
    timeout     = in_wait && (cnt_inc == TIMEOUT_CNT);
    done_hit    = (state_q == S_WAIT_DONE) && alu_done && !timeout;
    capture     = (state_q == S_WAIT_DONE) && alu_cmp && !timeout;
  end

  // Next-state selection; timeout wins over a same-cycle done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (accept) state_d = req_is_mode ? S_MODE : S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (timeout)        state_d = S_IDLE;
        else if (!alu_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (timeout || alu_done) state_d = S_IDLE;
      S_MODE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Control FSM with registered ALU controls, response and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ins_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
      flag_z_q     <= 1'b0;
      flag_c_q     <= 1'b0;
      flag_o_q     <= 1'b0;
      flag_n_q     <= 1'b0;
      start_q      <= 1'b0;
      oe_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= (state_d == S_ISSUE);
      oe_q    <= (state_d == S_WAIT_DONE);

      // operands are only visible to the ALU while an operation is live
      if (state_d == S_IDLE) begin
        ins_q <= '0;
        a_q   <= '0;
        b_q   <= '0;
      end else if (accept) begin
        ins_q <= req_ins;
        a_q   <= req_a;
        b_q   <= req_b;
      end

      if (state_q == S_ISSUE) cnt_q <= '0;
      else if (in_wait)       cnt_q <= cnt_inc;

      if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;

      if (timeout) begin
        rsp_valid_q  <= 1'b1;
        rsp_err_q    <= 1'b1;
        rsp_result_q <= '0;
      end else if (done_hit) begin
        rsp_valid_q  <= 1'b1;
        rsp_err_q    <= 1'b0;
        rsp_result_q <= alu_result;
      end else if (state_q == S_MODE) begin
        rsp_valid_q  <= 1'b1;
        rsp_err_q    <= 1'b0;
        rsp_result_q <= '0;
      end

      if (capture) begin
        if (ins_q == INS_CLR_CMP) begin
          flag_z_q <= 1'b0;
          flag_c_q <= 1'b0;
          flag_o_q <= 1'b0;
          flag_n_q <= 1'b0;
        end else begin
          flag_z_q <= (alu_result == 16'h0000);
          flag_c_q <= alu_carry;
          flag_o_q <= alu_over;
          flag_n_q <= alu_result[15];
        end
      end
    end
  end

  assign req_ready   = (state_q == S_IDLE) && !rsp_valid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_result  = rsp_result_q;
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;
  assign flag_o      = flag_o_q;
  assign flag_n      = flag_n_q;
  assign alu_start   = start_q;
  assign alu_oe      = oe_q;
  assign alu_carryin = flag_c_q;
  assign alu_cins    = ins_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized self-checking bench for alu_issue
module tb_alu_issue;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [7:0]  req_ins;
  logic [15:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic        flag_z, flag_c, flag_o, flag_n;
  logic        alu_start, alu_oe, alu_carryin;
  logic [7:0]  alu_cins;
  logic [15:0] alu_a, alu_b;
  logic        alu_done, alu_carry, alu_over, alu_cmp;
  logic [15:0] alu_result;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_flags;  // {z, c, o, n}

  alu_issue #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ins(req_ins),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .flag_z(flag_z), .flag_c(flag_c), .flag_o(flag_o), .flag_n(flag_n),
    .alu_start(alu_start), .alu_oe(alu_oe), .alu_carryin(alu_carryin),
    .alu_cins(alu_cins), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_carry(alu_carry), .alu_over(alu_over),
    .alu_cmp(alu_cmp), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // One operation: request at a negedge, ALU model drives done low for
  // 'busy' cycles starting the cycle after start (busy<0: done never rises),
  // response held for 'hold' cycles before rsp_ready.
  task automatic run_op(input logic [7:0] ins, input logic [15:0] a, input logic [15:0] b,
                        input int busy, input logic [15:0] res, input logic cy,
                        input logic ov, input logic cmp, input int hold, input string tag);
    logic        is_mode, tmo, exp_err;
    logic [15:0] exp_res;
    int          exp_lat, n, starts;
    bit          got, opnd_bad, idle_bad, stable_bad;
    is_mode = (ins >= 8'h51) && (ins <= 8'h54);
    tmo     = !is_mode && ((busy < 0) || (busy + 1 >= TMO));
    if (is_mode) begin
      exp_lat = 2; exp_err = 1'b0; exp_res = 16'h0000;
    end else if (tmo) begin
      exp_lat = TMO + 2; exp_err = 1'b1; exp_res = 16'h0000;
    end else begin
      exp_lat = 3 + busy; exp_err = 1'b0; exp_res = res;
      if (cmp) begin
        if (ins == 8'h50) exp_flags = 4'b0000;
        else exp_flags = {res == 16'h0000, cy, ov, res[15]};
      end
    end

    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL %s req_ready_idle got=%b exp=1", tag, req_ready);
    end
    req_valid = 1'b1; req_ins = ins; req_a = a; req_b = b;
    alu_result = res; alu_carry = cy; alu_over = ov; alu_cmp = cmp; alu_done = 1'b1;
    n = 0; got = 0; starts = 0; opnd_bad = 0; idle_bad = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (rsp_valid === 1'b1) begin
        got = 1;
        if (alu_cins !== 8'h00 || alu_a !== 16'h0 || alu_b !== 16'h0 || alu_start !== 1'b0) idle_bad = 1;
      end else begin
        if (alu_start === 1'b1) starts++;
        if (alu_cins !== ins || alu_a !== a || alu_b !== b || req_ready !== 1'b0) opnd_bad = 1;
        alu_done = (busy < 0) ? (n == 1) : !(n >= 2 && n <= busy + 1);
        req_ins = 8'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
      end
    end
    alu_done = 1'b1; alu_cmp = 1'b0;

    checks++;
    if (!got || n != exp_lat) begin
      failures++; $display("FAIL %s latency got=%0d exp=%0d (response seen=%0d)", tag, n, exp_lat, got);
    end
    checks++;
    if (rsp_err !== exp_err || rsp_result !== exp_res) begin
      failures++; $display("FAIL %s response got=%b/%h exp=%b/%h", tag, rsp_err, rsp_result, exp_err, exp_res);
    end
    checks++;
    if ({flag_z, flag_c, flag_o, flag_n, alu_carryin} !== {exp_flags, exp_flags[2]}) begin
      failures++; $display("FAIL %s flags_zcon_cin got=%b exp=%b", tag,
                           {flag_z, flag_c, flag_o, flag_n, alu_carryin}, {exp_flags, exp_flags[2]});
    end
    checks++;
    if (starts != (is_mode ? 0 : 1)) begin
      failures++; $display("FAIL %s start_cycles got=%0d exp=%0d", tag, starts, is_mode ? 0 : 1);
    end
    checks++;
    if (opnd_bad || idle_bad) begin
      failures++; $display("FAIL %s alu_operands got=busy_bad:%0d idle_bad:%0d exp=0/0", tag, opnd_bad, idle_bad);
    end

    stable_bad = 0;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_ins = 8'($urandom); req_a = 16'($urandom);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_result !== exp_res || req_ready !== 1'b0)
        stable_bad = 1;
    end
    checks++;
    if (stable_bad) begin
      failures++; $display("FAIL %s rsp_stable got=unstable exp=stable", tag);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL %s after_handshake got=%b%b exp=01", tag, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_ins = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    alu_done = 1'b1; alu_carry = 1'b0; alu_over = 1'b0; alu_cmp = 1'b0; alu_result = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_result, flag_z, flag_c, flag_o, flag_n, alu_start, alu_oe,
         alu_carryin, alu_cins, alu_a, alu_b} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b%b%h%b%b%b%b%b%b%b%h%h%h exp=all-zero",
        rsp_valid, rsp_err, rsp_result, flag_z, flag_c, flag_o, flag_n, alu_start, alu_oe,
        alu_carryin, alu_cins, alu_a, alu_b);
    end
    rst = 1'b0;
    exp_flags = 4'b0000;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_basic();
    run_op(8'h10, 16'h1200, 16'h0034, 6, 16'h1234, 1'b1, 1'b0, 1'b1, 0, "basic");
  endtask

  task automatic test_flags();
    run_op(8'h20, 16'h0001, 16'h0001, 6, 16'h0000, 1'b0, 1'b0, 1'b1, 0, "flag_zero");
    run_op(8'h21, 16'h7fff, 16'h0001, 6, 16'h8000, 1'b0, 1'b1, 1'b1, 0, "flag_neg");
    run_op(8'h50, 16'h0003, 16'h0003, 3, 16'h0000, 1'b1, 1'b1, 1'b1, 0, "clear_cmp");
    run_op(8'h22, 16'h0003, 16'h0004, 2, 16'hffff, 1'b1, 1'b0, 1'b1, 0, "flag_set");
  endtask

  task automatic test_mode();
    run_op(8'h52, 16'($urandom), 16'($urandom), 6, 16'h5a5a, 1'b0, 1'b1, 1'b1, 1, "mode_52");
  endtask

  task automatic test_timeout();
    run_op(8'h10, 16'h0011, 16'h0022, -1, 16'hbeef, 1'b0, 1'b1, 1'b0, 1, "timeout_never");
    run_op(8'h11, 16'h0033, 16'h0044, TMO - 1, 16'h4321, 1'b0, 1'b0, 1'b0, 0, "timeout_edge");
    run_op(8'h12, 16'h0055, 16'h0066, TMO - 2, 16'h0042, 1'b0, 1'b0, 1'b1, 0, "last_before_timeout");
  endtask

  task automatic test_back_to_back();
    run_op(8'h30, 16'h1111, 16'h2222, 2, 16'h3333, 1'b0, 1'b0, 1'b1, 5, "backpressure");
    run_op(8'h31, 16'h4444, 16'h5555, 1, 16'h9999, 1'b1, 1'b1, 1'b1, 0, "back_to_back");
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_ins = 8'h40; req_a = 16'habcd; req_b = 16'h1234;
    alu_done = 1'b1; alu_cmp = 1'b0;
    @(negedge clk);                 // ISSUE
    req_valid = 1'b0;
    @(negedge clk);                 // WAIT_BUSY
    alu_done = 1'b0;
    @(negedge clk);                 // WAIT_DONE
    checks++;
    if (alu_oe !== 1'b1 || alu_cins !== 8'h40) begin
      failures++; $display("FAIL reset_mid_pre got=oe:%b cins:%h exp=oe:1 cins:40", alu_oe, alu_cins);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_result, flag_z, flag_c, flag_o, flag_n, alu_start, alu_oe,
         alu_cins, alu_a, alu_b} !== '0) begin
      failures++; $display("FAIL reset_mid_outputs got=%b%b%h %b%b%b%b %b%b %h%h%h exp=all-zero",
        rsp_valid, rsp_err, rsp_result, flag_z, flag_c, flag_o, flag_n, alu_start, alu_oe,
        alu_cins, alu_a, alu_b);
    end
    exp_flags = 4'b0000;
    @(negedge clk);
    rst = 1'b0; alu_done = 1'b1;
    run_op(8'h41, 16'h0f0f, 16'hf0f0, 4, 16'hffff, 1'b1, 1'b0, 1'b1, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] ins;
    logic [15:0] res;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 9))
        0:       ins = 8'h50;
        1:       ins = 8'h51 + 8'($urandom_range(0, 3));
        default: ins = 8'($urandom);
      endcase
      res = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      run_op(ins, 16'($urandom), 16'($urandom), $urandom_range(1, TMO - 2), res,
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_mode();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
